// File: rtl/rnd_pkg.sv
// Shared definitions for the rounding arbiter slice: default widths,
// the result record and a helper for the saturation constant.
package rnd_pkg;

  localparam int unsigned WIDTH_I_DEF = 10;
  localparam int unsigned WIDTH_O_DEF = 4;
  localparam int unsigned N_REQ_DEF   = 4;
  localparam int unsigned ID_W_DEF    = $clog2(N_REQ_DEF);

  // One rounded result as seen by the consumer, at default widths
  typedef struct packed {
    logic [WIDTH_O_DEF-1:0] man;
    logic                   ofl;
    logic [ID_W_DEF-1:0]    id;
  } rnd_res_t;

  // All-ones pattern of the given width, right-aligned in 32 bits
  function automatic logic [31:0] sat_ones(input int unsigned w);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < w) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rnd_rne.sv
// Round-to-nearest-even of an augmented mantissa down to width_o bits.
// The bits below the kept field are guard (first dropped bit) and sticky
// (OR of the rest); a carry out of the kept field is reported as o_ofl.
module rnd_rne
  import rnd_pkg::*;
#(
  parameter int unsigned width_i = WIDTH_I_DEF,
  parameter int unsigned width_o = WIDTH_O_DEF
) (
  input  logic [width_i-1:0] i_num,
  output logic [width_o-1:0] o_man,
  output logic               o_ofl
);

  logic [width_o-1:0] keep;
  logic               guard;
  logic               sticky;
  logic               rnd_up;

  // Round up above half, or at exactly half when the kept lsb is odd
  always_comb begin
    keep   = i_num[width_i-1 -: width_o];
    guard  = i_num[width_i-width_o-1];
    sticky = |i_num[width_i-width_o-2:0];
    rnd_up = guard & (sticky | keep[0]);
    {o_ofl, o_man} = {1'b0, keep} + (width_o+1)'(rnd_up);
  end

endmodule

// File: rtl/rr_arb.sv
// Round-robin arbiter: searches from ptr+1 upward with wrap and grants the
// first active request while enabled. ptr follows the last accepted index.
module rr_arb
  import rnd_pkg::*;
#(
  parameter  int unsigned n_req = N_REQ_DEF,
  localparam int unsigned id_w  = $clog2(n_req)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [n_req-1:0] i_req,
  input  logic             i_en,
  input  logic             i_ack,
  output logic [n_req-1:0] o_gnt,
  output logic [id_w-1:0]  o_idx
);

  logic [id_w-1:0] ptr;

  // Wrap-order search; the index is reduced by subtraction so that
  // non-power-of-two n_req wraps correctly
  always_comb begin
    int unsigned     cand;
    logic [id_w-1:0] idx;
    logic            found;
    o_gnt = '0;
    o_idx = '0;
    found = 1'b0;
    cand  = 0;
    idx   = '0;
    for (int unsigned off = 1; off <= n_req; off++) begin
      cand = 32'(ptr) + off;
      if (cand >= n_req) cand = cand - n_req;
      idx = cand[id_w-1:0];
      if (i_en && !found && i_req[idx]) begin
        found      = 1'b1;
        o_gnt[idx] = 1'b1;
        o_idx      = idx;
      end
    end
  end

  // Pointer moves only on an accepted transfer; reset gives requester 0 priority
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)     ptr <= id_w'(n_req - 1);
    else if (i_ack) ptr <= o_idx;
  end

endmodule

// File: rtl/rnd_rne_arb.sv
// Shares one rnd_rne unit between n_req requesters through a round-robin
// arbiter and a two-stage pipeline (S1 operand, S2 result) with backpressure.
// Optional: RND_RNE_ARB_SAT_EN saturates the mantissa to all ones on overflow.
module rnd_rne_arb
  import rnd_pkg::*;
#(
  parameter  int unsigned width_i = WIDTH_I_DEF,
  parameter  int unsigned width_o = WIDTH_O_DEF,
  parameter  int unsigned n_req   = N_REQ_DEF,
  localparam int unsigned id_w    = $clog2(n_req)
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [n_req-1:0]                i_vld,
  input  logic [n_req-1:0][width_i-1:0]   i_num,
  output logic [n_req-1:0]                o_rdy,
  output logic                            o_vld,
  output logic [width_o-1:0]              o_man,
  output logic                            o_ofl,
  output logic [id_w-1:0]                 o_id,
  input  logic                            i_rdy
);

  typedef struct packed {
    logic [width_o-1:0] man;
    logic               ofl;
    logic [id_w-1:0]    id;
  } res_t;

  logic               s1_v, s2_v;
  logic [width_i-1:0] s1_num;
  logic [id_w-1:0]    s1_id;
  res_t               s2_r;

  logic               s2_load, s1_load, arb_en, xfer;
  logic [n_req-1:0]   gnt;
  logic [id_w-1:0]    gnt_idx;
  logic [width_o-1:0] rnd_man, nxt_man;
  logic               rnd_ofl, nxt_ofl;

  // Stage advance; the arbiter is also held off while reset is asserted
  always_comb begin
    s2_load = s1_v && (!s2_v || i_rdy);
    s1_load = !s1_v || s2_load;
    arb_en  = s1_load && i_rst;
    xfer    = |(i_vld & gnt);
  end

  rr_arb #(.n_req(n_req)) u_arb (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_req (i_vld),
    .i_en  (arb_en),
    .i_ack (xfer),
    .o_gnt (gnt),
    .o_idx (gnt_idx)
  );

  rnd_rne #(.width_i(width_i), .width_o(width_o)) u_rnd (
    .i_num (s1_num),
    .o_man (rnd_man),
    .o_ofl (rnd_ofl)
  );

`ifdef RND_RNE_ARB_SAT_EN
  localparam logic [31:0] SAT_ALL = sat_ones(width_o);
  // Saturate the mantissa whenever rounding carries out
  always_comb begin
    nxt_ofl = rnd_ofl;
    nxt_man = rnd_ofl ? SAT_ALL[width_o-1:0] : rnd_man;
  end
`else
  // Pass the rounder result through unchanged
  always_comb begin
    nxt_ofl = rnd_ofl;
    nxt_man = rnd_man;
  end
`endif

  // S1: capture the granted operand and its index
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      s1_v   <= 1'b0;
      s1_num <= '0;
      s1_id  <= '0;
    end else if (s1_load) begin
      s1_v <= xfer;
      if (xfer) begin
        s1_num <= i_num[gnt_idx];
        s1_id  <= gnt_idx;
      end
    end
  end

  // S2: register the rounded result; holds while downstream stalls
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      s2_v <= 1'b0;
      s2_r <= '0;
    end else if (s2_load) begin
      s2_v <= 1'b1;
      s2_r <= '{man: nxt_man, ofl: nxt_ofl, id: s1_id};
    end else if (i_rdy) begin
      s2_v <= 1'b0;
    end
  end

  assign o_rdy = gnt;
  assign o_vld = s2_v;
  assign o_man = s2_r.man;
  assign o_ofl = s2_r.ofl;
  assign o_id  = s2_r.id;

endmodule
